register_file_param: RTL and testbench

Parametrised successor to the CPU's 2-read/1-write register file, sitting between decode (read addresses) and writeback (write port) in the datapath. It adds configurable width and depth, a hardwired zero register (LEGv8 XZR), and out-of-range address handling. It also adds a sequenced clear engine that zeroes the array one entry per cycle after reset or on request, plus an optional same-cycle write-to-read bypass.

---
 rtl/register_file_param.sv | 105 ++++++++++
 tb/tb_register_file_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// Parametrised 2-read/1-write register file with hardwired zero register and a
// one-entry-per-cycle clear sweep. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file_param #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic              Clear,
  output logic [WIDTH-1:0]  Data1,
  output logic [WIDTH-1:0]  Data2,
  output logic              Busy,
  output logic [0:0]        dbg_state_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam bit                ZERO_EN  = (ZERO_REG < DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG % (1 << ADDR_W));

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  rf_q [DEPTH];
  logic              wr_fire;

  // An address is "live" when it maps to a real, writable/readable register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_EN && (a == ZERO_IDX));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_SWEEP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (Clear) begin
      state_d = ST_SWEEP;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear beats a same-cycle write; writes are dropped while sweeping.
  assign wr_fire = (state_q == ST_IDLE) && RegWrite && !Clear && addr_live(WriteReg);

  // Array has no reset: the sweep is what zeroes it.
  always_ff @(posedge CLK) begin
    if (state_q == ST_SWEEP) begin
      rf_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      rf_q[WriteReg] <= WriteData;
    end
  end

  always_comb begin
    Data1 = '0;
    if ((state_q == ST_IDLE) && addr_live(Read1)) begin
`ifdef RF_BYPASS_EN
      if (wr_fire && (WriteReg == Read1)) Data1 = WriteData;
      else                                Data1 = rf_q[Read1];
`else
      Data1 = rf_q[Read1];
`endif
    end
  end

  always_comb begin
    Data2 = '0;
    if ((state_q == ST_IDLE) && addr_live(Read2)) begin
`ifdef RF_BYPASS_EN
      if (wr_fire && (WriteReg == Read2)) Data2 = WriteData;
      else                                Data2 = rf_q[Read2];
`else
      Data2 = rf_q[Read2];
`endif
    end
  end

  assign Busy        = state_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a default 32-entry instance and a 20-entry instance
// share stimulus; an array-level model plus literal expectations check both.
module tb_register_file_param;

  localparam int DEP_A = 32;
  localparam int DEP_B = 20;
  localparam int ZR    = 31;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  read1, read2, write_reg;
  logic [63:0] write_data;
  logic        reg_write, clear;
  logic [63:0] data1_a, data2_a, data1_b, data2_b;
  logic        busy_a, busy_b;
  logic [0:0]  dbg_a, dbg_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // model state: remaining sweep edges (0 = idle) and register contents
  int          left_a = DEP_A;
  int          left_b = DEP_B;
  logic [63:0] mem_a [32];
  logic [63:0] mem_b [32];

  // clock / reset block
  always #5 clk = ~clk;

  register_file_param u_dut_a (
    .CLK(clk), .RESET_N(rst_n), .Read1(read1), .Read2(read2), .WriteReg(write_reg),
    .WriteData(write_data), .RegWrite(reg_write), .Clear(clear),
    .Data1(data1_a), .Data2(data2_a), .Busy(busy_a), .dbg_state_o(dbg_a)
  );

  register_file_param #(.DEPTH(DEP_B)) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .Read1(read1), .Read2(read2), .WriteReg(write_reg),
    .WriteData(write_data), .RegWrite(reg_write), .Clear(clear),
    .Data1(data1_b), .Data2(data2_b), .Busy(busy_b), .dbg_state_o(dbg_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit legal(input bit sel, input logic [4:0] a);
    int dep = sel ? DEP_B : DEP_A;
    return (int'(a) < dep) && !((ZR < dep) && (int'(a) == ZR));
  endfunction

  function automatic logic [63:0] exp_rd(input bit sel, input logic [4:0] ra);
    int left = sel ? left_b : left_a;
    if (left != 0 || !legal(sel, ra)) return 64'h0;
`ifdef RF_BYPASS_EN
    if (reg_write && !clear && legal(sel, write_reg) && write_reg == ra) return write_data;
`endif
    return sel ? mem_b[ra] : mem_a[ra];
  endfunction

  // A sweep is modelled as "busy for DEPTH edges, then the whole array is zero".
  task automatic model_edge(input bit sel);
    int dep  = sel ? DEP_B : DEP_A;
    int left = sel ? left_b : left_a;
    if (left > 0) begin
      left--;
      if (left == 0)
        for (int i = 0; i < 32; i++) begin
          if (sel) mem_b[i] = 64'h0; else mem_a[i] = 64'h0;
        end
    end else if (clear) begin
      left = dep;
    end else if (reg_write && legal(sel, write_reg)) begin
      if (sel) mem_b[write_reg] = write_data; else mem_a[write_reg] = write_data;
    end
    if (sel) left_b = left; else left_a = left;
  endtask

  always @(negedge rst_n) begin
    left_a = DEP_A;
    left_b = DEP_B;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      left_a = DEP_A;
      left_b = DEP_B;
    end else begin
      model_edge(1'b0);
      model_edge(1'b1);
    end
  end

  // compare process: every mid-cycle, both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_busy",  {63'h0, busy_a}, {63'h0, left_a != 0});
      chk("b_busy",  {63'h0, busy_b}, {63'h0, left_b != 0});
      chk("a_data1", data1_a, exp_rd(1'b0, read1));
      chk("a_data2", data2_a, exp_rd(1'b0, read2));
      chk("b_data1", data1_b, exp_rd(1'b1, read1));
      chk("b_data2", data2_b, exp_rd(1'b1, read2));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic clr, input logic [4:0] r1, input logic [4:0] r2);
    reg_write  = we;
    write_reg  = wa;
    write_data = wd;
    clear      = clr;
    read1      = r1;
    read2      = r2;
  endtask

  // Counts edges until each Busy is seen low; 0 means it never fell within budget.
  task automatic count_sweep(output int na, output int nb);
    int n = 0;
    na = 0;
    nb = 0;
    while ((na == 0 || nb == 0) && n < 100) begin
      step();
      n++;
      if (!busy_a && na == 0) na = n;
      if (!busy_b && nb == 0) nb = n;
    end
  endtask

  int na, nb;

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd3, 5'd30);
    #3;
    rst_n  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {63'h0, busy_a}, 64'h1);
    chk("rst_data1", data1_a, 64'h0);
    step();
    rst_n = 1'b1;
    count_sweep(na, nb);
    chk("reset_sweep_a", 64'(na), 64'd32);
    chk("reset_sweep_b", 64'(nb), 64'd20);

    // write then read back
    drive(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 5'd5, 5'd6);
    step();
    reg_write = 1'b0;
    @(negedge clk);
    chk("wr_rd_a", data1_a, 64'hDEAD_BEEF_0123_4567);
    chk("wr_rd_b", data1_b, 64'hDEAD_BEEF_0123_4567);
    chk("rd_other", data2_a, 64'h0);

    // zero register
    step();
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd31, 5'd5);
    @(negedge clk);
    chk("zero_same_cycle", data1_a, 64'h0);
    step();
    reg_write = 1'b0;
    @(negedge clk);
    chk("zero_after", data1_a, 64'h0);

    // bypass
    step();
    drive(1'b1, 5'd7, 64'h11, 1'b0, 5'd7, 5'd7);
    step();
    drive(1'b1, 5'd7, 64'h55, 1'b0, 5'd7, 5'd5);
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("bypass_before", data1_a, 64'h55);
`else
    chk("bypass_before", data1_a, 64'h11);
`endif
    step();
    reg_write = 1'b0;
    @(negedge clk);
    chk("bypass_after", data1_a, 64'h55);

    // fill, then clear racing a write
    for (int i = 0; i < 31; i++) begin
      step();
      drive(1'b1, 5'(i), 64'(i + 1), 1'b0, 5'd30, 5'd19);
    end
    step();
    reg_write = 1'b0;
    @(negedge clk);
    chk("fill_a30", data1_a, 64'd31);
    chk("fill_b19", data2_b, 64'd20);
    step();
    drive(1'b1, 5'd2, 64'h99, 1'b1, 5'd2, 5'd3);
    step();
    clear     = 1'b0;
    reg_write = 1'b0;
    count_sweep(na, nb);
    chk("clear_sweep_a", 64'(na), 64'd32);
    chk("clear_sweep_b", 64'(nb), 64'd20);
    for (int i = 0; i < 32; i += 2) begin
      read1 = 5'(i);
      read2 = 5'(i + 1);
      @(negedge clk);
      chk("cleared_r1", data1_a, 64'h0);
      chk("cleared_r2", data2_a, 64'h0);
      step();
    end

    // reset in the middle of a sweep
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_sweep(na, nb);
    chk("midrst_sweep_a", 64'(na), 64'd32);
    chk("midrst_sweep_b", 64'(nb), 64'd20);

    // out-of-range write on the 20-entry instance
    drive(1'b1, 5'd25, 64'h2525, 1'b0, 5'd25, 5'd25);
    step();
    reg_write = 1'b0;
    @(negedge clk);
    chk("oor_b", data1_b, 64'h0);
    chk("inrange_a", data1_a, 64'h2525);
    step();
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
